// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised multi-port register file with per-register busy scoreboard and sequential clear engine.
// Latency: reads are combinational (0 cycles); writes/reserves land on the next rising edge; clear takes DEPTH cycles.
// Backpressure: none; writes/reserves arriving while clear_busy is high are dropped and flagged on wr_drop.
// Optional build macro REG_FILE_SB_BYPASS_EN: forwards same-cycle write data/busy onto matching read ports.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] PW,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic [DATA_W-1:0] PD,
    input  logic              res_en,
    input  logic [ADDR_W-1:0] res_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_d,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]   busy_q;

    logic               wr_go;
    logic               res_go;

    logic [ADDR_W-1:0]  rd_addr [3];
    logic [DATA_W-1:0]  rd_dat  [3];
    logic [2:0]         rd_busy;

    // Register 0 is hardwired only when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // FSM next state, clear counter advance, drop detection and write/reserve qualification.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = 1'b0;
        wr_go     = 1'b0;
        res_go    = 1'b0;
        case (state_q)
            IDLE: begin
                wr_go  = enable && !is_zero_reg(RW);
                res_go = res_en && !is_zero_reg(res_addr);
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // Every write or reserve request is lost while clearing, address 0 included.
                wr_drop_d = enable || res_en;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, clear counter and drop pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage and scoreboard update: clear engine owns the array while active; otherwise reserve overrides write on busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q]  <= '0;
            busy_q[cnt_q] <= 1'b0;
        end else begin
            if (wr_go) begin
                mem_q[RW]  <= PW;
                busy_q[RW] <= 1'b0;
            end
            if (res_go) begin
                busy_q[res_addr] <= 1'b1;
            end
        end
    end

`ifdef REG_FILE_SB_BYPASS_EN
    logic byp_ok;
    assign byp_ok = !reset && (state_q == IDLE) && enable;
`endif

    // Combinational read ports with optional same-cycle forwarding of the pending write.
    always_comb begin
        rd_addr[0] = RA;
        rd_addr[1] = RB;
        rd_addr[2] = RD;
        for (int p = 0; p < 3; p++) begin
            rd_dat[p]  = mem_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
`ifdef REG_FILE_SB_BYPASS_EN
            if (byp_ok && (rd_addr[p] == RW)) begin
                rd_dat[p]  = PW;
                rd_busy[p] = res_en && (res_addr == RW);
            end
`endif
            if (is_zero_reg(rd_addr[p])) begin
                rd_dat[p]  = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign PA         = rd_dat[0];
    assign PB         = rd_dat[1];
    assign PD         = rd_dat[2];
    assign busy_a     = rd_busy[0];
    assign busy_b     = rd_busy[1];
    assign busy_d     = rd_busy[2];
    assign clear_busy = (state_q == CLEAR);
    assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed scenarios plus randomized traffic against an array-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared 2 units after it.
// The model assumes default parameters (32 x 32, register 0 hardwired).
module tb_reg_file_sb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  RW = '0, RA = '0, RB = '0, RD = '0, res_addr = '0;
    logic [31:0] PW = '0;
    logic        res_en = 1'b0;
    logic        clear_req = 1'b0;
    logic [31:0] PA, PB, PD;
    logic        busy_a, busy_b, busy_d, clear_busy, wr_drop;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain arrays plus remaining clear length and next index to zero.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    int          m_clr_left = 0;
    int          m_clr_idx  = 0;
    bit          m_drop     = 0;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .RW(RW), .PW(PW),
        .RA(RA), .RB(RB), .RD(RD), .PA(PA), .PB(PB), .PD(PD),
        .res_en(res_en), .res_addr(res_addr),
        .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d),
        .clear_req(clear_req), .clear_busy(clear_busy), .wr_drop(wr_drop)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_dat(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REG_FILE_SB_BYPASS_EN
        if (!reset && m_clr_left == 0 && enable && a == RW) return PW;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_bsy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
        if (!reset && m_clr_left == 0 && enable && a == RW) return res_en && (res_addr == a);
`endif
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_clr_left = 0;
        m_clr_idx  = 0;
        m_drop     = 0;
    endtask

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic tick();
        if (m_clr_left > 0) begin
            m_drop = enable || res_en;
            m_mem[m_clr_idx]  = 32'h0;
            m_busy[m_clr_idx] = 1'b0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            m_drop = 0;
            if (enable && RW != 0) begin
                m_mem[RW]  = PW;
                m_busy[RW] = 1'b0;
            end
            if (res_en && res_addr != 0) m_busy[res_addr] = 1'b1;
            if (clear_req) begin
                m_clr_left = 32;
                m_clr_idx  = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        enable = 0; res_en = 0; clear_req = 0;
    endtask

    task automatic test_reset();
        model_reset();
        RA = 5'd1; RB = 5'd2; RD = 5'd31;
        #1;
        n_checks++;
        if ({PA, PB, PD, busy_a, busy_b, busy_d, clear_busy, wr_drop} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got PA=%h PB=%h PD=%h busy=%b%b%b cb=%b drop=%b, need all 0",
                     PA, PB, PD, busy_a, busy_b, busy_d, clear_busy, wr_drop);
        end
        @(posedge clock); #1;
        reset = 0;
        enable = 1; RW = 5'd5; PW = 32'hDEADBEEF;
        tick();
        quiet();
        RA = 5'd5;
        #1;
        n_checks++;
        if (PA !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL pre_reset_write: PA=%h need DEADBEEF", PA);
        end
        #1 reset = 1;
        #1;
        n_checks++;
        if (PA !== 32'h0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: PA=%h busy_a=%b need 0/0", PA, busy_a);
        end
        model_reset();
        #1 reset = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read();
        enable = 1; RW = 5'd3; PW = 32'h12345678;
        tick();
        quiet();
        RA = 5'd3; RB = 5'd3; RD = 5'd3;
        #1;
        n_checks++;
        if (PA !== 32'h12345678 || PB !== 32'h12345678 || PD !== 32'h12345678) begin
            n_fail++; $display("FAIL write_read: PA=%h PB=%h PD=%h need 12345678", PA, PB, PD);
        end
        enable = 1; RW = 5'd0; PW = 32'hFFFFFFFF;
        tick();
        quiet();
        RA = 5'd0;
        #1;
        n_checks++;
        if (PA !== 32'h0 || wr_drop !== 1'b0) begin
            n_fail++; $display("FAIL zero_reg: PA=%h wr_drop=%b need 0/0", PA, wr_drop);
        end
    endtask

    task automatic test_reserve();
        res_en = 1; res_addr = 5'd7;
        tick();
        quiet();
        RA = 5'd7;
        #1;
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL reserve_set: busy_a=%b need 1", busy_a);
        end
        enable = 1; RW = 5'd7; PW = 32'h55;
        tick();
        quiet();
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || PA !== 32'h55) begin
            n_fail++; $display("FAIL write_clears_busy: busy_a=%b PA=%h need 0/55", busy_a, PA);
        end
        enable = 1; RW = 5'd9; PW = 32'hCAFE0009; res_en = 1; res_addr = 5'd9;
        tick();
        quiet();
        RB = 5'd9;
        #1;
        n_checks++;
        if (busy_b !== 1'b1 || PB !== 32'hCAFE0009) begin
            n_fail++; $display("FAIL write_and_reserve: busy_b=%b PB=%h need 1/CAFE0009", busy_b, PB);
        end
        res_en = 1; res_addr = 5'd0;
        tick();
        quiet();
        RD = 5'd0;
        #1;
        n_checks++;
        if (busy_d !== 1'b0 || wr_drop !== 1'b0) begin
            n_fail++; $display("FAIL reserve_zero: busy_d=%b wr_drop=%b need 0/0", busy_d, wr_drop);
        end
    endtask

    task automatic test_clear();
        int busy_cycles = 0;
        int k;
        for (int i = 1; i < 32; i++) begin
            enable = 1; RW = 5'(i); PW = 32'(i);
            res_en = (i % 5 == 0); res_addr = 5'(i);
            tick();
        end
        quiet();
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int i = 0; i < 40 && clear_busy === 1'b1; i++) begin
            busy_cycles++;
            k = $urandom_range(31);
            RA = 5'(k);
            #1;
            n_checks++;
            if (PA !== ((k < i || k == 0) ? 32'h0 : 32'(k))) begin
                n_fail++; $display("FAIL clear_partial: cyc=%0d reg=%0d PA=%h need %h", i, k, PA,
                                   (k < i || k == 0) ? 32'h0 : 32'(k));
            end
            tick();
        end
        n_checks++;
        if (busy_cycles != 32) begin
            n_fail++; $display("FAIL clear_duration: clear_busy high %0d cycles need 32", busy_cycles);
        end
        for (int a = 0; a < 32; a++) begin
            RA = 5'(a);
            #1;
            n_checks++;
            if (PA !== 32'h0 || busy_a !== 1'b0 || clear_busy !== 1'b0) begin
                n_fail++; $display("FAIL clear_result: reg=%0d PA=%h busy=%b cb=%b need 0/0/0",
                                   a, PA, busy_a, clear_busy);
            end
        end
    endtask

    task automatic test_clear_drop();
        int busy_cycles = 0;
        clear_req = 1;
        tick();
        quiet();
        for (int i = 0; i < 40 && clear_busy === 1'b1; i++) begin
            busy_cycles++;
            if (i == 3) begin
                enable = 1; RW = 5'd4; PW = 32'hAA; clear_req = 1;
            end else if (i == 10) begin
                enable = 1; RW = 5'd0; PW = 32'h1;
            end else begin
                quiet();
            end
            tick();
            if (i == 3 || i == 10 || i == 4 || i == 11) begin
                n_checks++;
                if (wr_drop !== ((i == 3 || i == 10) ? 1'b1 : 1'b0)) begin
                    n_fail++; $display("FAIL wr_drop_pulse: cyc=%0d wr_drop=%b need %b", i, wr_drop,
                                       (i == 3 || i == 10));
                end
            end
        end
        quiet();
        RA = 5'd4;
        #1;
        n_checks++;
        if (busy_cycles != 32 || PA !== 32'h0) begin
            n_fail++; $display("FAIL clear_drop_result: busy cycles %0d PA=%h need 32/0", busy_cycles, PA);
        end
    endtask

    task automatic test_clear_abort();
        enable = 1; RW = 5'd20; PW = 32'h2020;
        tick();
        quiet();
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int i = 0; i < 5; i++) tick();
        #1 reset = 1;
        #1;
        n_checks++;
        if (clear_busy !== 1'b0 || PA !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_clear: clear_busy=%b PA=%h need 0/0", clear_busy, PA);
        end
        model_reset();
        #1 reset = 0;
        @(posedge clock); #1;
        enable = 1; RW = 5'd6; PW = 32'h66;
        tick();
        quiet();
        RA = 5'd6;
        #1;
        n_checks++;
        if (PA !== 32'h66 || clear_busy !== 1'b0) begin
            n_fail++; $display("FAIL after_abort: PA=%h cb=%b need 66/0", PA, clear_busy);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        enable = 1; RW = 5'd2; PW = 32'h1;
        tick();
        enable = 1; RW = 5'd2; PW = 32'h2; RA = 5'd2;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        want = 32'h2;
`else
        want = 32'h1;
`endif
        n_checks++;
        if (PA !== want) begin
            n_fail++; $display("FAIL bypass_same_cycle: PA=%h need %h", PA, want);
        end
        tick();
        quiet();
        #1;
        n_checks++;
        if (PA !== 32'h2) begin
            n_fail++; $display("FAIL bypass_next_cycle: PA=%h need 2", PA);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            enable    = ($urandom_range(2) != 0);
            res_en    = ($urandom_range(3) == 0);
            clear_req = ($urandom_range(60) == 0);
            RW        = 5'($urandom_range(31));
            PW        = $urandom;
            res_addr  = ($urandom_range(1) != 0) ? RW : 5'($urandom_range(31));
            RA        = ($urandom_range(3) == 0) ? RW : 5'($urandom_range(31));
            RB        = 5'($urandom_range(31));
            RD        = ($urandom_range(3) == 0) ? res_addr : 5'($urandom_range(31));
            #1;
            n_checks++;
            if (PA !== exp_dat(RA) || PB !== exp_dat(RB) || PD !== exp_dat(RD)) begin
                n_fail++; $display("FAIL rand_data: it=%0d PA=%h/%h PB=%h/%h PD=%h/%h (got/need)", n,
                                   PA, exp_dat(RA), PB, exp_dat(RB), PD, exp_dat(RD));
            end
            n_checks++;
            if ({busy_a, busy_b, busy_d} !== {exp_bsy(RA), exp_bsy(RB), exp_bsy(RD)}) begin
                n_fail++; $display("FAIL rand_busy: it=%0d busy=%b%b%b need %b%b%b", n,
                                   busy_a, busy_b, busy_d, exp_bsy(RA), exp_bsy(RB), exp_bsy(RD));
            end
            n_checks++;
            if (clear_busy !== (m_clr_left > 0) || wr_drop !== m_drop) begin
                n_fail++; $display("FAIL rand_ctrl: it=%0d cb=%b drop=%b need %b/%b", n,
                                   clear_busy, wr_drop, (m_clr_left > 0), m_drop);
            end
            tick();
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reserve();
        test_clear();
        test_clear_drop();
        test_clear_abort();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the fixed 32x32 three-read-port register file.
- Data width and depth are configurable.
- Adds a per-register scoreboard (busy bits) for hazard detection and a sequential clear engine that zeroes the array one entry per cycle.
- Sits in the datapath between decode (reserve, read) and writeback (write).

Parameters:
DATA_W, 32, width of each register and of PW/PA/PB/PD
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores write/reserve; 0 = register 0 is ordinary

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  write enable for PW into register RW
RW  in  ADDR_W  write address
PW  in  DATA_W  write data
RA  in  ADDR_W  read address A
RB  in  ADDR_W  read address B
RD  in  ADDR_W  read address D
PA  out  DATA_W  read data A, combinational
PB  out  DATA_W  read data B, combinational
PD  out  DATA_W  read data D, combinational
res_en  in  1  reserve request: set busy bit of res_addr
res_addr  in  ADDR_W  register to reserve
busy_a  out  1  busy bit of RA, combinational
busy_b  out  1  busy bit of RB, combinational
busy_d  out  1  busy bit of RD, combinational
clear_req  in  1  start the clear sequence
clear_busy  out  1  high while the clear sequence runs
wr_drop  out  1  registered one-cycle pulse: a write or reserve was discarded

Behaviour:
- Reset (async, active-high):
  - All registers and busy bits = 0.
  - FSM = IDLE, clear counter = 0.
  - clear_busy = 0, wr_drop = 0.
  - PA/PB/PD and busy_* read 0.
  - Reset mid-clear aborts the sequence immediately.
- Reads are combinational with 0 cycles latency. A write at edge N is visible on read ports after edge N (no same-cycle forwarding unless the optional feature is on).
- ZERO_REG=1:
  - Address 0 reads data 0 and busy 0.
  - Write and reserve to address 0 are silently ignored; wr_drop is not pulsed.
- Write: on the edge with enable=1 in IDLE, reg[RW] <= PW and busy[RW] <= 0.
- Reserve: on the edge with res_en=1 in IDLE, busy[res_addr] <= 1.
- Simultaneous write and reserve to the same address: data is written and busy ends at 1 (reserve wins). Different addresses: both take effect.
- FSM states:
  - IDLE: clear_busy=0. clear_req=1 moves to CLEAR with counter <= 0.
  - CLEAR: clear_busy=1. Each edge: reg[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt+1. When cnt == DEPTH-1, return to IDLE and wrap cnt to 0.
  - clear_busy is high for exactly DEPTH cycles, starting the cycle after clear_req is sampled.
- During CLEAR:
  - clear_req is ignored.
  - Any enable=1 or res_en=1 is discarded, and wr_drop pulses high for one cycle after that edge. This includes writes to address 0.
  - Reads return current contents, which may be partially cleared.
- clear_req and enable in the same IDLE cycle: the write is performed, then CLEAR begins. The cleared result overrides it.
- Every stored register is DATA_W bits. No arithmetic is performed.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - In IDLE, when enable=1 and a read address equals RW (and it is not address 0 with ZERO_REG=1), that read port returns PW in the same cycle.
  - The matching busy_* reads 0 in the same cycle, unless res_en=1 with res_addr also equal to that address.
  - No bypass during CLEAR.
- Undefined: read ports return stored contents only; busy_* reflect stored busy bits only.

Test Plan:
1. Assert reset mid-cycle after writing reg5=0xDEADBEEF -> PA with RA=5 reads 0 immediately (async), busy_a=0.
2. Write reg3=0x12345678 (enable=1) -> next cycle PA/PB/PD all read 0x12345678 with RA=RB=RD=3. Write reg0=0xFFFFFFFF (ZERO_REG=1) -> PA reads 0.
3. res_en=1, res_addr=7 -> busy_a=1 next cycle for RA=7. Write reg7=0x55 -> busy_a=0, PA=0x55. Same-edge write+reserve on reg9 -> busy=1, data written.
4. Fill regs 1..31 with index value, pulse clear_req -> clear_busy high exactly 32 cycles. Mid-sequence, reg k reads 0 for k < cnt and k for k >= cnt. After the sequence, all regs read 0 and all busy bits are 0.
5. enable=1 RW=4 PW=0xAA during CLEAR -> wr_drop pulses 1 cycle, reg4 stays 0. Second clear_req mid-sequence -> total busy duration stays 32.
6. With REG_FILE_SB_BYPASS_EN: reg2=0x1, then write PW=0x2 RW=2 with RA=2 -> PA=0x2 in the same cycle. Without the macro -> PA=0x1 that cycle, 0x2 next.
